// File: rtl/rot_coord_gen_if.sv
// Request/response bundle of the rotation coordinate generator: destination
// pixel requests in, source coordinates and bilinear weights out.
interface rot_coord_gen_if #(
  parameter int PIX_W  = 12,
  parameter int FRAC_W = 10,
  parameter int TRIG_W = FRAC_W + 2
);
  logic                     i_fsyn;
  logic                     i_valid;
  logic                     o_ready;
  logic [PIX_W-1:0]         iv_width;
  logic [PIX_W-1:0]         iv_depth;
  logic signed [TRIG_W-1:0] iv_cos;
  logic signed [TRIG_W-1:0] iv_sin;
  logic                     o_valid;
  logic                     i_ready;
  logic signed [PIX_W:0]    ov_x0;
  logic signed [PIX_W:0]    ov_y0;
  logic [FRAC_W-1:0]        ov_fx;
  logic [FRAC_W-1:0]        ov_fy;
  logic                     o_oob;
  logic                     o_eol;
  logic                     o_eof;

  modport slave (
    input  i_fsyn, i_valid, iv_width, iv_depth, iv_cos, iv_sin, i_ready,
    output o_ready, o_valid, ov_x0, ov_y0, ov_fx, ov_fy, o_oob, o_eol, o_eof
  );

  modport master (
    output i_fsyn, i_valid, iv_width, iv_depth, iv_cos, iv_sin, i_ready,
    input  o_ready, o_valid, ov_x0, ov_y0, ov_fx, ov_fy, o_oob, o_eol, o_eof
  );
endinterface

// File: rtl/rot_coord_gen.sv
// Raster-scan inverse-mapping rotation coordinate generator, 4-stage pipeline
// from destination (x,y) to floor source coordinate, weights and oob flag.
module rot_coord_gen #(
  parameter int PIX_W  = 12,
  parameter int FRAC_W = 10,
  parameter int TRIG_W = FRAC_W + 2,
  parameter int DEF_W  = 640,
  parameter int DEF_H  = 480
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  rot_coord_gen_if.slave    bus
);
  localparam int DW   = PIX_W + 1;
  localparam int PW   = DW + TRIG_W;
  localparam int SUMW = PW + 1;
  localparam int SW   = SUMW + 1;
  localparam int X0W  = SW - FRAC_W;
  localparam logic signed [X0W-1:0] SAT_HI = X0W'((1 << (DW - 1)) - 1);
  localparam logic signed [X0W-1:0] SAT_LO = ~SAT_HI;

  // Handshake: a request is taken when i_valid && o_ready and i_fsyn is low;
  // a beat leaves when o_valid && i_ready. o_ready mirrors i_ready, and the
  // whole pipe plus the scan counters freeze in any cycle with i_ready low.
  logic adv, acc;
  assign adv         = bus.i_ready;
  assign acc         = bus.i_valid & adv & ~bus.i_fsyn;
  assign bus.o_ready = bus.i_ready;

  logic [PIX_W-1:0]         w_q, h_q, x_q, y_q;
  logic signed [TRIG_W-1:0] c_q, s_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      w_q <= PIX_W'(DEF_W);
      h_q <= PIX_W'(DEF_H);
      c_q <= TRIG_W'(1 << FRAC_W);
      s_q <= '0;
    end else if (bus.i_fsyn) begin
      w_q <= bus.iv_width;
      h_q <= bus.iv_depth;
      c_q <= bus.iv_cos;
      s_q <= bus.iv_sin;
    end
  end

  logic x_last, y_last;
  assign x_last = (x_q == w_q - PIX_W'(1));
  assign y_last = (y_q == h_q - PIX_W'(1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (bus.i_fsyn) begin
      x_q <= '0;
      y_q <= '0;
    end else if (acc) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + PIX_W'(1);
      end else begin
        x_q <= x_q + PIX_W'(1);
      end
    end
  end

  // Each beat carries the config it was accepted under, so a new frame's
  // config never leaks into beats still in flight.
  logic [PIX_W-1:0]     cx, cy;
  logic signed [DW-1:0] dx_c, dy_c;
  assign cx   = w_q >> 1;
  assign cy   = h_q >> 1;
  assign dx_c = $signed({1'b0, x_q}) - $signed({1'b0, cx});
  assign dy_c = $signed({1'b0, cy}) - $signed({1'b0, y_q});

  logic                     v1, eol1, eof1;
  logic signed [DW-1:0]     dx1, dy1;
  logic [PIX_W-1:0]         cx1, cy1, w1, h1;
  logic signed [TRIG_W-1:0] c1, s1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v1 <= 1'b0; eol1 <= 1'b0; eof1 <= 1'b0;
      dx1 <= '0; dy1 <= '0; cx1 <= '0; cy1 <= '0; w1 <= '0; h1 <= '0;
      c1 <= '0; s1 <= '0;
    end else if (adv) begin
      v1   <= acc;
      eol1 <= x_last;
      eof1 <= x_last & y_last;
      dx1  <= dx_c;
      dy1  <= dy_c;
      cx1  <= cx;
      cy1  <= cy;
      w1   <= w_q;
      h1   <= h_q;
      c1   <= c_q;
      s1   <= s_q;
    end
  end

  logic signed [PW-1:0] c_ext, s_ext, dx_ext, dy_ext;
  assign c_ext  = {{DW{c1[TRIG_W-1]}}, c1};
  assign s_ext  = {{DW{s1[TRIG_W-1]}}, s1};
  assign dx_ext = {{TRIG_W{dx1[DW-1]}}, dx1};
  assign dy_ext = {{TRIG_W{dy1[DW-1]}}, dy1};

  logic                 v2, eol2, eof2;
  logic signed [PW-1:0] pcx, psy, psx, pcy;
  logic [PIX_W-1:0]     cx2, cy2, w2, h2;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v2 <= 1'b0; eol2 <= 1'b0; eof2 <= 1'b0;
      pcx <= '0; psy <= '0; psx <= '0; pcy <= '0;
      cx2 <= '0; cy2 <= '0; w2 <= '0; h2 <= '0;
    end else if (adv) begin
      v2   <= v1;
      eol2 <= eol1;
      eof2 <= eof1;
      pcx  <= c_ext * dx_ext;
      psy  <= s_ext * dy_ext;
      psx  <= s_ext * dx_ext;
      pcy  <= c_ext * dy_ext;
      cx2  <= cx1;
      cy2  <= cy1;
      w2   <= w1;
      h2   <= h1;
    end
  end

  logic signed [SUMW-1:0] px_c, py_c;
  logic signed [SW-1:0]   sx_c, sy_c;
  assign px_c = $signed({pcx[PW-1], pcx}) - $signed({psy[PW-1], psy});
  assign py_c = $signed({psx[PW-1], psx}) + $signed({pcy[PW-1], pcy});
  assign sx_c = $signed({{(SW-PIX_W-FRAC_W){1'b0}}, cx2, {FRAC_W{1'b0}}})
              + $signed({px_c[SUMW-1], px_c});
  assign sy_c = $signed({{(SW-PIX_W-FRAC_W){1'b0}}, cy2, {FRAC_W{1'b0}}})
              - $signed({py_c[SUMW-1], py_c});

  logic                 v3, eol3, eof3;
  logic signed [SW-1:0] sx3, sy3;
  logic [PIX_W-1:0]     w3, h3;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v3 <= 1'b0; eol3 <= 1'b0; eof3 <= 1'b0;
      sx3 <= '0; sy3 <= '0; w3 <= '0; h3 <= '0;
    end else if (adv) begin
      v3   <= v2;
      eol3 <= eol2;
      eof3 <= eof2;
      sx3  <= sx_c;
      sy3  <= sy_c;
      w3   <= w2;
      h3   <= h2;
    end
  end

  // Dropping the fraction bits of a two's-complement value is a floor.
  logic signed [X0W-1:0] x0_w, y0_w, lim_x, lim_y;
  logic                  oob_c;
  assign x0_w  = sx3[SW-1:FRAC_W];
  assign y0_w  = sy3[SW-1:FRAC_W];
  assign lim_x = $signed({{(X0W-PIX_W){1'b0}}, w3}) - $signed(X0W'(2));
  assign lim_y = $signed({{(X0W-PIX_W){1'b0}}, h3}) - $signed(X0W'(2));
  assign oob_c = x0_w[X0W-1] | (x0_w > lim_x) | y0_w[X0W-1] | (y0_w > lim_y);

  function automatic logic [DW-1:0] sat(input logic signed [X0W-1:0] v);
    if (v > SAT_HI)      sat = SAT_HI[DW-1:0];
    else if (v < SAT_LO) sat = SAT_LO[DW-1:0];
    else                 sat = v[DW-1:0];
  endfunction

  logic                 v4, oob4, eol4, eof4;
  logic [DW-1:0]        x04, y04;
  logic [FRAC_W-1:0]    fx4, fy4;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v4 <= 1'b0; oob4 <= 1'b0; eol4 <= 1'b0; eof4 <= 1'b0;
      x04 <= '0; y04 <= '0; fx4 <= '0; fy4 <= '0;
    end else if (adv) begin
      v4   <= v3;
      oob4 <= oob_c;
      eol4 <= eol3;
      eof4 <= eof3;
      x04  <= sat(x0_w);
      y04  <= sat(y0_w);
      fx4  <= sx3[FRAC_W-1:0];
      fy4  <= sy3[FRAC_W-1:0];
    end
  end

  assign bus.o_valid = v4;
  assign bus.ov_x0   = $signed(x04);
  assign bus.ov_y0   = $signed(y04);
  assign bus.ov_fx   = fx4;
  assign bus.ov_fy   = fy4;
  assign bus.o_oob   = oob4;
  assign bus.o_eol   = eol4;
  assign bus.o_eof   = eof4;
endmodule

// File: tb/tb_rot_coord_gen.sv
// Bench for rot_coord_gen: directed angle/latch/reset cases plus random
// valid/ready traffic against an arithmetic reference model.
module tb_rot_coord_gen;
  localparam int PIX_W  = 12;
  localparam int FRAC_W = 10;
  localparam int TRIG_W = 12;
  localparam int BW     = 49;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rot_coord_gen_if #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .TRIG_W(TRIG_W)) bus ();

  rot_coord_gen #(
    .PIX_W(PIX_W), .FRAC_W(FRAC_W), .TRIG_W(TRIG_W), .DEF_W(640), .DEF_H(480)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(input longint x0, input longint y0,
                                         input longint fx, input longint fy,
                                         input bit oob, input bit eol, input bit eof);
    logic [12:0] a, b;
    logic [9:0]  c, d;
    a = x0[12:0]; b = y0[12:0]; c = fx[9:0]; d = fy[9:0];
    return {a, b, c, d, oob, eol, eof};
  endfunction

  function automatic longint sat13(input longint v);
    if (v > 4095)  return 4095;
    if (v < -4096) return -4096;
    return v;
  endfunction

  // Reference: rotate about the centre in plain integer arithmetic, then take
  // floor and fraction by modulo rather than bit slicing.
  function automatic logic [BW-1:0] model(input int x, input int y, input int w, input int h,
                                          input int c, input int s, input bit eol, input bit eof);
    longint cx, cy, dx, dy, sx, sy, fx, fy, x0, y0;
    bit oob;
    cx = w / 2;  cy = h / 2;
    dx = x - cx; dy = cy - y;
    sx = cx * 1024 + (longint'(c) * dx - longint'(s) * dy);
    sy = cy * 1024 - (longint'(s) * dx + longint'(c) * dy);
    fx = ((sx % 1024) + 1024) % 1024;
    fy = ((sy % 1024) + 1024) % 1024;
    x0 = (sx - fx) / 1024;
    y0 = (sy - fy) / 1024;
    oob = (x0 < 0) || (x0 > w - 2) || (y0 < 0) || (y0 > h - 2);
    return pack(sat13(x0), sat13(y0), fx, fy, oob, eol, eof);
  endfunction

  logic [BW-1:0] exp_q[$];
  int            acc_cyc_q[$];
  int            acc_stl_q[$];
  logic [BW-1:0] out_log[$];
  bit            log_en = 0;

  int mw, mh, mc, ms, mx, my;
  int cyc = 0;
  int stall_cnt = 0;
  bit prev_stall = 0;
  logic [BW:0] prev_obs;

  logic [BW-1:0] obs;
  assign obs = {bus.ov_x0, bus.ov_y0, bus.ov_fx, bus.ov_fy, bus.o_oob, bus.o_eol, bus.o_eof};

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete(); acc_cyc_q.delete(); acc_stl_q.delete();
      mw = 640; mh = 480; mc = 1024; ms = 0; mx = 0; my = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) check_eq("stall_hold", 64'({bus.o_valid, obs}), 64'(prev_obs));
      if (bus.o_valid && bus.i_ready) begin
        check_eq("beat_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          int n0, s0;
          check_eq("beat", 64'(obs), 64'(exp_q.pop_front()));
          n0 = acc_cyc_q.pop_front();
          s0 = acc_stl_q.pop_front();
          check_eq("latency", 64'(cyc - n0 - (stall_cnt - s0)), 64'(4));
        end
        if (log_en) out_log.push_back(obs);
      end
      if (!bus.i_ready) stall_cnt++;
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_obs   = {bus.o_valid, obs};
      if (bus.i_fsyn) begin
        mw = int'(bus.iv_width); mh = int'(bus.iv_depth);
        mc = int'($signed(bus.iv_cos)); ms = int'($signed(bus.iv_sin));
        mx = 0; my = 0;
      end else if (bus.i_valid && bus.i_ready) begin
        bit eol, eof;
        eol = (mx == mw - 1);
        eof = eol && (my == mh - 1);
        exp_q.push_back(model(mx, my, mw, mh, mc, ms, eol, eof));
        acc_cyc_q.push_back(cyc);
        acc_stl_q.push_back(stall_cnt);
        if (eol) begin
          mx = 0;
          my = (my == mh - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit r, input bit f);
    bus.i_valid = v;
    bus.i_ready = r;
    bus.i_fsyn  = f;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int w, input int h, input int c, input int s);
    bus.iv_width = PIX_W'(w);
    bus.iv_depth = PIX_W'(h);
    bus.iv_cos   = TRIG_W'(c);
    bus.iv_sin   = TRIG_W'(s);
  endtask

  task automatic new_frame(input int w, input int h, input int c, input int s);
    set_cfg(w, h, c, s);
    drive(0, 1, 1);
  endtask

  task automatic stream(input int n);
    repeat (n) drive(1, 1, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      drive(0, 1, 0);
      k++;
    end
    drive(0, 1, 0);
    check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int eol_n, eof_n;
    bus.i_valid = 0; bus.i_ready = 1; bus.i_fsyn = 0;
    set_cfg(640, 480, 1024, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(bus.o_valid), 64'(0));
    check_eq("rst_outputs", 64'(obs), 64'(0));
    bus.i_ready = 0; #1;
    check_eq("rst_ready_lo", 64'(bus.o_ready), 64'(0));
    bus.i_ready = 1; #1;
    check_eq("rst_ready_hi", 64'(bus.o_ready), 64'(1));
    rst_n = 1;
    drive(0, 1, 0);

    // Identity rotation, full frame plus one restart pixel.
    new_frame(8, 6, 1024, 0);
    out_log.delete(); log_en = 1;
    stream(49);
    drain();
    check_eq("id_count", 64'(out_log.size()), 64'(49));
    if (out_log.size() == 49) begin
      check_eq("id_p00", 64'(out_log[0]), 64'(pack(0, 0, 0, 0, 0, 0, 0)));
      check_eq("id_p75", 64'(out_log[47]), 64'(pack(7, 5, 0, 0, 1, 1, 1)));
      check_eq("id_restart", 64'(out_log[48]), 64'(pack(0, 0, 0, 0, 0, 0, 0)));
      eol_n = 0; eof_n = 0;
      for (int i = 0; i < 48; i++) begin
        eol_n += int'(out_log[i][1]);
        eof_n += int'(out_log[i][0]);
      end
      check_eq("id_eol_cnt", 64'(eol_n), 64'(6));
      check_eq("id_eof_cnt", 64'(eof_n), 64'(1));
    end

    // 45 degrees.
    new_frame(8, 6, 724, 724);
    out_log.delete();
    stream(48);
    drain();
    check_eq("r45_count", 64'(out_log.size()), 64'(48));
    if (out_log.size() == 48) begin
      check_eq("r45_p00", 64'(out_log[0]), 64'(pack(-1, 3, 52, 724, 1, 0, 0)));
      check_eq("r45_p53", 64'(out_log[29]), 64'(pack(4, 2, 724, 300, 0, 0, 0)));
    end

    // 90 degrees.
    new_frame(8, 6, 0, 1024);
    out_log.delete();
    stream(1);
    drain();
    check_eq("r90_count", 64'(out_log.size()), 64'(1));
    if (out_log.size() == 1)
      check_eq("r90_p00", 64'(out_log[0]), 64'(pack(1, 7, 0, 0, 1, 0, 0)));

    // Mid-frame trig change takes effect only at the next frame start;
    // a request coinciding with i_fsyn is dropped.
    new_frame(8, 6, 1024, 0);
    out_log.delete();
    stream(10);
    bus.iv_cos = TRIG_W'(724);
    bus.iv_sin = TRIG_W'(724);
    stream(38);
    drive(1, 1, 1);
    stream(1);
    drain();
    check_eq("latch_count", 64'(out_log.size()), 64'(49));
    if (out_log.size() == 49) begin
      check_eq("latch_old", 64'(out_log[10]), 64'(pack(2, 1, 0, 0, 0, 0, 0)));
      check_eq("latch_new", 64'(out_log[48]), 64'(pack(-1, 3, 52, 724, 1, 0, 0)));
    end
    log_en = 0;

    // Random traffic with backpressure and occasional reconfiguration.
    new_frame(5, 4, 900, -300);
    for (int i = 0; i < 800; i++) begin
      bit f;
      f = ($urandom_range(0, 99) == 0);
      if (f) set_cfg($urandom_range(1, 16), $urandom_range(1, 12),
                     int'($urandom_range(0, 4095)) - 2048,
                     int'($urandom_range(0, 4095)) - 2048);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f);
    end
    drain();

    // Asynchronous reset with four beats in flight.
    new_frame(8, 6, 1024, 0);
    stream(4);
    check_eq("inflight_valid", 64'(bus.o_valid), 64'(1));
    #2 rst_n = 0;
    #1;
    check_eq("mrst_valid", 64'(bus.o_valid), 64'(0));
    check_eq("mrst_outputs", 64'(obs), 64'(0));
    check_eq("mrst_ready", 64'(bus.o_ready), 64'(1));
    drive(0, 1, 0);
    drive(0, 1, 0);
    rst_n = 1;
    out_log.delete(); log_en = 1;
    stream(640);
    drain();
    log_en = 0;
    check_eq("def_count", 64'(out_log.size()), 64'(640));
    if (out_log.size() == 640) begin
      check_eq("def_p00", 64'(out_log[0]), 64'(pack(0, 0, 0, 0, 0, 0, 0)));
      check_eq("def_eol", 64'(out_log[639]), 64'(pack(639, 0, 0, 0, 1, 1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rot_coord_gen.md
# rot_coord_gen

Parametrised inverse-mapping coordinate generator for the image rotation datapath. It scans destination pixels in raster order and rotates each destination coordinate about the image centre by a signed angle (sin/cos). For each pixel it emits the integer source coordinate, the bilinear fractional weights and an out-of-bounds flag to the downstream fetch/interpolation stage. Compared with the earlier point generator, it adds signed full-circle trig inputs, frame-latched configuration, a registered 4-stage pipeline with valid/ready backpressure, floor-correct negative coordinates, and line/frame markers.

## Interface
- PIX_W, 12: coordinate counter width; max image dimension 2^PIX_W-1
- FRAC_W, 10: fractional bits of trig inputs and output weights
- TRIG_W, FRAC_W+2: signed trig width, Q1.FRAC_W, 1.0 = 2^FRAC_W
- DEF_W, 640 / DEF_H, 480: shadow width/depth after reset
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_fsyn  in  1  frame-start pulse; clears counters, latches config
- i_valid  in  1  destination pixel request
- o_ready  out  1  request accepted when i_valid && o_ready; equals i_ready
- iv_width, iv_depth  in  PIX_W  image width/height, latched on i_fsyn
- iv_cos, iv_sin  in  TRIG_W signed  rotation trig, latched on i_fsyn
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- ov_x0, ov_y0  out  PIX_W+1 signed  floor of source coordinate
- ov_fx, ov_fy  out  FRAC_W  fractional part of source coordinate, 0..2^FRAC_W-1
- o_oob  out  1  bilinear 2x2 neighbourhood not fully inside image
- o_eol, o_eof  out  1  beat is last of line / last of frame

## Operation
- Shadow regs: W, H, C, S. Reset values are DEF_W, DEF_H, 2^FRAC_W, 0. They update only in the cycle i_fsyn is high, so a mid-frame change of iv_* has no effect until the next i_fsyn.
- Counters x (0..W-1) and y (0..H-1) step on each accepted request. x wraps at W-1 and increments y. y wraps at H-1 to 0, giving auto-restart without i_fsyn.
- i_fsyn has priority. It zeroes x and y, and any i_valid in the same cycle is discarded (no output beat). i_fsyn does not flush beats already in the pipeline.
- Each accepted pixel carries (x,y) into the pipeline with:
  - cx = W>>1, cy = H>>1
  - dx = x - cx, dy = cy - y, signed PIX_W+1
- Rotation: px = C·dx - S·dy and py = S·dx + C·dy. Products are full-precision signed; the sums carry one extra bit (no truncation).
- Source coordinate, fixed point with FRAC_W fraction:
  - sx = (cx<<FRAC_W) + px
  - sy = (cy<<FRAC_W) - py
- Outputs:
  - ov_x0 = sx >>> FRAC_W (arithmetic shift, i.e. floor); ov_fx = sx[FRAC_W-1:0]. Same rule for y.
  - ov_x0/ov_y0 saturate to the signed PIX_W+1 range.
- o_oob = 1 when x0<0, x0>W-2, y0<0, or y0>H-2.
- o_eol = (x==W-1) and o_eof = (x==W-1 && y==H-1), both evaluated at acceptance and carried down the pipe.

## Timing
- Pipeline stages:
  - S1: registered dx, dy and markers.
  - S2: registered products.
  - S3: registered sx, sy.
  - S4: registered outputs and o_oob.
- Latency: a request accepted at cycle n produces o_valid at n+4 when i_ready stays high.
- Stall: when i_ready=0, all stages and counters hold, o_ready=0, and outputs stay stable. The bench must see no data loss or duplication across any stall pattern.
- Throughput: 1 pixel/cycle when i_valid=i_ready=1.
- Bubbles: i_valid=0 inserts bubbles that propagate as o_valid=0.
- Reset (asynchronous, any time, including mid-frame):
  - All stage valid bits clear and o_valid=0.
  - x=y=0.
  - Shadow regs return to their defaults.
  - ov_* = 0, o_oob = o_eol = o_eof = 0.
  - o_ready follows i_ready.

## Test plan
- Identity: W=8, H=6, C=1024, S=0, stream 48 pixels. Pixel (0,0) gives x0=0, y0=0, fx=fy=0, oob=0. Pixel (7,5) gives x0=7, y0=5, oob=1. o_eol at x=7; o_eof only on beat 48; the 49th pixel restarts at (0,0).
- 45°: W=8, H=6, C=S=724.
  - Pixel (5,3) gives x0=4, fx=724, y0=2, fy=300, oob=0.
  - Pixel (0,0) gives x0=-1, fx=52 (floor of negative), oob=1.
- 90°: C=0, S=1024, W=8, H=6. Pixel (0,0) gives x0=1, y0=7, fx=fy=0, oob=1.
- Config latch: change iv_sin mid-frame. Outputs of the current frame are unchanged; the new value applies only after the next i_fsyn. i_fsyn together with i_valid produces no beat, and the next request maps to (0,0).
- Backpressure: random i_ready (50%) and random i_valid. The output sequence must match a golden model, with latency 4 when unstalled and outputs held constant while i_ready=0.
- Reset mid-frame: assert i_reset_n=0 with 4 beats in flight. o_valid drops immediately and all outputs are 0. After release, the first request maps to (0,0) using DEF_W/DEF_H, C=1.0, S=0.
